// File: rtl/mmio_uart_io_pkg.sv
// Shared register map, state encodings and helpers for the MMIO UART/LED slave.
package mmio_pkg;

  localparam logic [31:0] ADDR_LED    = 32'h0000_C000;
  localparam logic [31:0] ADDR_SW     = 32'h0000_C001;
  localparam logic [31:0] ADDR_TXDATA = 32'h0000_C004;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_C005;
  localparam logic [31:0] ADDR_RXDATA = 32'h0000_C006;
  localparam logic [31:0] ADDR_DIV    = 32'h0000_C008;
  localparam logic [31:0] DEAD_WORD   = 32'h0000_DEAD;

  localparam logic [15:0] MIN_DIV = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Divisors below MIN_DIV leave no room for the half-bit start sample.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    if (d < MIN_DIV) return MIN_DIV;
    return d;
  endfunction

endpackage

// File: rtl/mmio_uart_io_if.sv
// CPU external data bus as seen by the MMIO slave.
interface mmio_uart_io_if;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output re, output we, output wdata, input rdata);
  modport slave  (input addr, input re, input we, input wdata, output rdata);
endinterface

// File: rtl/mmio_uart_io_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is accepted only if a pop frees a slot.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/mmio_uart_io.sv
// MMIO slave above DM space: LED register, synchronised switches, 8N1 UART with TX FIFO, baud divisor.
module mmio_uart_io
  import mmio_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int unsigned TX_DEPTH    = 8,
  parameter int unsigned LED_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  mmio_uart_io_if.slave    bus,
  input  logic [LED_W-1:0] sw,
  output logic [LED_W-1:0] led,
  input  logic             uart_rx,
  output logic             uart_tx
);
  logic [LED_W-1:0] sw_s1, sw_s2;
  logic             rx_s1, rx_s2, rx_prev;
  logic [15:0]      div;

  logic wr_led, wr_tx, wr_status, wr_div, rd_rx, clr_ovr;
  assign wr_led    = bus.we && (bus.addr == ADDR_LED);
  assign wr_tx     = bus.we && (bus.addr == ADDR_TXDATA);
  assign wr_status = bus.we && (bus.addr == ADDR_STATUS);
  assign wr_div    = bus.we && (bus.addr == ADDR_DIV);
  assign rd_rx     = bus.re && (bus.addr == ADDR_RXDATA);
  assign clr_ovr   = wr_status && bus.wdata[3];

  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[31:16];

  // TX side
  tx_state_t   tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_end, tx_pop, tx_line, tx_idle;
  logic [7:0]  fifo_dout;
  logic        tx_full, tx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_tx),
    .din   (bus.wdata[7:0]),
    .pop   (tx_pop),
    .dout  (fifo_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign tx_end  = (tx_cnt == tx_div - 16'd1);
  assign tx_pop  = !tx_empty && ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_end));
  assign tx_idle = tx_empty && (tx_state == TX_IDLE);

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      TX_START: tx_line = 1'b0;
      TX_DATA:  tx_line = tx_sh[0];
      default:  tx_line = 1'b1;
    endcase
  end

  // uart_tx is the registered image of the state, so the line trails the pop by two edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_div   <= 16'(DEFAULT_DIV);
      uart_tx  <= 1'b1;
    end else begin
      uart_tx <= tx_line;
      case (tx_state)
        TX_IDLE: if (tx_pop) begin
          tx_state <= TX_START;
          tx_sh    <= fifo_dout;
          tx_div   <= div;
          tx_cnt   <= '0;
        end
        TX_START: if (tx_end) begin
          tx_state <= TX_DATA;
          tx_cnt   <= '0;
          tx_bit   <= '0;
        end else tx_cnt <= tx_cnt + 16'd1;
        TX_DATA: if (tx_end) begin
          tx_cnt <= '0;
          tx_sh  <= {1'b0, tx_sh[7:1]};
          tx_bit <= tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state <= TX_STOP;
        end else tx_cnt <= tx_cnt + 16'd1;
        TX_STOP: if (tx_end) begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_state <= TX_START;
            tx_sh    <= fifo_dout;
            tx_div   <= div;
          end else tx_state <= TX_IDLE;
        end else tx_cnt <= tx_cnt + 16'd1;
      endcase
    end
  end

  // RX side
  rx_state_t   rx_state;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh, rx_byte;
  logic        rx_valid, rx_ovr, rx_end, rx_half, rx_done;

  assign rx_end  = (rx_cnt == rx_div - 16'd1);
  assign rx_half = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign rx_done = (rx_state == RX_STOP) && rx_end && rx_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_prev <= 1'b0;
      led     <= '0;
      div     <= 16'(DEFAULT_DIV);
    end else begin
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (wr_led) led <= bus.wdata[LED_W-1:0];
      if (wr_div) div <= clamp_div(bus.wdata[15:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_div   <= 16'(DEFAULT_DIV);
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      case (rx_state)
        RX_IDLE: if (rx_prev && !rx_s2) begin
          rx_state <= RX_START;
          rx_cnt   <= '0;
          rx_div   <= div;
        end
        RX_START: if (rx_half) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_DATA: if (rx_end) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 16'd1;
        RX_STOP: if (rx_end) begin
          rx_cnt   <= '0;
          rx_state <= RX_IDLE;
        end else rx_cnt <= rx_cnt + 16'd1;
      endcase

      // A read coinciding with a new byte consumes the old one, so no overrun.
      if (rx_done) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rd_rx) begin
        rx_valid <= 1'b0;
      end
      if (rx_done && rx_valid && !rd_rx) rx_ovr <= 1'b1;
      else if (clr_ovr)                  rx_ovr <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = DEAD_WORD;
    case (bus.addr)
      ADDR_LED:    bus.rdata = {{(32-LED_W){1'b0}}, led};
      ADDR_SW:     bus.rdata = {{(32-LED_W){1'b0}}, sw_s2};
      ADDR_STATUS: bus.rdata = {28'b0, rx_ovr, rx_valid, tx_full, tx_idle};
      ADDR_RXDATA: bus.rdata = {24'b0, rx_byte};
      ADDR_DIV:    bus.rdata = {16'b0, div};
      default:     bus.rdata = DEAD_WORD;
    endcase
  end
endmodule
